// File: rtl/ysyx_ifu_fetch_queue.sv
// Instruction-fetch front end: one outstanding word read on the ifu port, returned
// {pc, inst} pairs queued toward decode; redirects flush the queue and drain a stale read.
module ysyx_ifu_fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h3000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic [ADDR_W-1:0]          ifu_araddr_o,
  output logic                       ifu_arvalid_o,
  input  logic [DATA_W-1:0]          ifu_rdata,
  input  logic                       ifu_rvalid,
  output logic [DATA_W-1:0]          out_inst_o,
  output logic [ADDR_W-1:0]          out_pc_o,
  output logic                       out_valid_o,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] stale_pc_q, stale_pc_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] mem_pc_q   [DEPTH];
  logic [DATA_W-1:0] mem_inst_q [DEPTH];

  logic              push, pop;
  logic [ADDR_W-1:0] redir_aligned;

  assign redir_aligned = redirect_pc & ~ADDR_W'(3);
  assign pop           = (count_q != '0) && out_ready;
  assign push          = (state_q == S_REQ) && ifu_rvalid && !redirect_valid;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    stale_pc_d = stale_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    // A redirect wins over any same-cycle pop or push.
    if (redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end

    case (state_q)
      S_IDLE: begin
        if (redirect_valid) fetch_pc_d = redir_aligned;
        if (count_d < CW'(DEPTH)) state_d = S_REQ;
      end
      S_REQ: begin
        if (redirect_valid) begin
          fetch_pc_d = redir_aligned;
          if (!ifu_rvalid) begin
            stale_pc_d = fetch_pc_q;
            state_d    = S_DROP;
          end
        end else if (ifu_rvalid) begin
          fetch_pc_d = fetch_pc_q + ADDR_W'(4);
          state_d    = (count_d < CW'(DEPTH)) ? S_REQ : S_IDLE;
        end
      end
      S_DROP: begin
        if (redirect_valid) fetch_pc_d = redir_aligned;
        if (ifu_rvalid)     state_d    = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      stale_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      stale_pc_q <= stale_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage is data only; occupancy is tracked by count_q, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc_q[wr_ptr_q]   <= fetch_pc_q;
      mem_inst_q[wr_ptr_q] <= ifu_rdata;
    end
  end

  assign ifu_arvalid_o = (state_q == S_REQ) || (state_q == S_DROP);
  assign ifu_araddr_o  = (state_q == S_DROP) ? stale_pc_q : fetch_pc_q;
  assign out_valid_o   = (count_q != '0);
  assign out_pc_o      = out_valid_o ? mem_pc_q[rd_ptr_q]   : '0;
  assign out_inst_o    = out_valid_o ? mem_inst_q[rd_ptr_q] : '0;
  assign count_o       = count_q;

endmodule

// File: tb/tb_ysyx_ifu_fetch_queue.sv
// Bench for ysyx_ifu_fetch_queue: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_ysyx_ifu_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, redirect_valid, ifu_rvalid, out_ready;
  logic [31:0] redirect_pc, ifu_rdata;
  logic [31:0] ifu_araddr_o, out_inst_o, out_pc_o;
  logic        ifu_arvalid_o, out_valid_o;
  logic [2:0]  count_o;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Reference model: phase 0 idle, 1 requesting, 2 draining a stale read.
  int          m_ph;
  logic [31:0] m_pc, m_stale;
  logic [63:0] m_q[$];

  always #5 clk = ~clk;

  ysyx_ifu_fetch_queue #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'h3000_0000)
  ) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ifu_araddr_o(ifu_araddr_o), .ifu_arvalid_o(ifu_arvalid_o),
    .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid),
    .out_inst_o(out_inst_o), .out_pc_o(out_pc_o), .out_valid_o(out_valid_o),
    .out_ready(out_ready), .count_o(count_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [63:0] head;
    head = (m_q.size() != 0) ? m_q[0] : 64'd0;
    chk("arvalid",   64'(ifu_arvalid_o), 64'(m_ph != 0));
    chk("araddr",    64'(ifu_araddr_o),  64'((m_ph == 2) ? m_stale : m_pc));
    chk("count",     64'(count_o),       64'(m_q.size()));
    chk("out_valid", 64'(out_valid_o),   64'(m_q.size() != 0));
    chk("out_pc",    64'(out_pc_o),      64'(head[63:32]));
    chk("out_inst",  64'(out_inst_o),    64'(head[31:0]));
  endtask

  task automatic model_step(input bit r, input bit rd, input logic [31:0] rpc,
                            input bit rv, input logic [31:0] data, input bit rdy);
    logic [63:0] dropped;
    if (r) begin
      m_ph = 0; m_pc = 32'h3000_0000; m_stale = 32'h3000_0000; m_q.delete();
      return;
    end
    if (rd) begin
      m_q.delete();
      if (m_ph == 0) m_ph = 1;
      else if (m_ph == 1 && !rv) begin m_stale = m_pc; m_ph = 2; end
      else if (m_ph == 2 && rv) m_ph = 1;
      m_pc = rpc & 32'hFFFF_FFFC;
    end else begin
      if (m_q.size() > 0 && rdy) dropped = m_q.pop_front();
      if (m_ph == 0) begin
        if (m_q.size() < DEPTH) m_ph = 1;
      end else if (m_ph == 1) begin
        if (rv) begin
          m_q.push_back({m_pc, data});
          m_pc = m_pc + 32'd4;
          m_ph = (m_q.size() < DEPTH) ? 1 : 0;
        end
      end else if (rv) m_ph = 1;
    end
  endtask

  task automatic step(input bit r, input bit rd, input logic [31:0] rpc,
                      input bit rv, input logic [31:0] data, input bit rdy);
    rst = r; redirect_valid = rd; redirect_pc = rpc;
    ifu_rvalid = rv; ifu_rdata = data; out_ready = rdy;
    model_step(r, rd, rpc, rv, data, rdy);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [31:0] last_pc, seen_pc;
    logic [2:0]  cnt_before;
    bit          have_last, both;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    ifu_rvalid = 1'b0; ifu_rdata = '0; out_ready = 1'b0;
    @(negedge clk);

    // Reset state
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_arvalid", 64'(ifu_arvalid_o), 64'd0);
    chk("rst_araddr",  64'(ifu_araddr_o),  64'h3000_0000);
    chk("rst_count",   64'(count_o),       64'd0);
    chk("rst_outpc",   64'(out_pc_o),      64'd0);

    // First fetch, bus answers after three cycles of arvalid
    step(0, 0, 0, 0, 0, 0);
    chk("t1_arvalid", 64'(ifu_arvalid_o), 64'd1);
    chk("t1_araddr",  64'(ifu_araddr_o),  64'h3000_0000);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h0000_0013, 0);
    chk("t1_valid",   64'(out_valid_o),  64'd1);
    chk("t1_outpc",   64'(out_pc_o),     64'h3000_0000);
    chk("t1_inst",    64'(out_inst_o),   64'h13);
    chk("t1_nextadr", 64'(ifu_araddr_o), 64'h3000_0004);

    // Fill with decode stalled, then a single pop restarts fetch
    for (int i = 0; i < 40 && m_q.size() < DEPTH; i++) step(0, 0, 0, m_ph == 1, $urandom, 0);
    chk("t2_count",   64'(count_o),       64'd4);
    chk("t2_arvalid", 64'(ifu_arvalid_o), 64'd0);
    step(0, 0, 0, 0, 0, 1);
    chk("t2_rearm",   64'(ifu_arvalid_o), 64'd1);
    chk("t2_araddr",  64'(ifu_araddr_o),  64'h3000_0010);

    // Redirect while a read waits: flush, stale read drained and discarded
    step(0, 1, 32'h8000_0002, 0, 0, 0);
    chk("t3_count",   64'(count_o),       64'd0);
    chk("t3_arvalid", 64'(ifu_arvalid_o), 64'd1);
    chk("t3_stale",   64'(ifu_araddr_o),  64'h3000_0010);
    step(0, 0, 0, 1, 32'hBAD0_BAD0, 0);
    chk("t3_nopush",  64'(count_o),       64'd0);
    chk("t3_newadr",  64'(ifu_araddr_o),  64'h8000_0000);

    // Redirect coincident with the response
    step(0, 1, 32'h4000_0100, 1, 32'hDEAD_BEEF, 0);
    chk("t4_count",  64'(count_o),      64'd0);
    chk("t4_araddr", 64'(ifu_araddr_o), 64'h4000_0100);

    // Full FIFO, then concurrent pop and push keep occupancy and order
    for (int i = 0; i < 40 && m_q.size() < DEPTH; i++) step(0, 0, 0, m_ph == 1, $urandom, 0);
    have_last = 1'b0;
    last_pc   = '0;
    for (int i = 0; i < 12; i++) begin
      both       = (m_ph == 1) && (m_q.size() > 0);
      seen_pc    = out_pc_o;
      cnt_before = count_o;
      step(0, 0, 0, m_ph == 1, $urandom, 1);
      if (both) chk("t5_count_same", 64'(count_o), 64'(cnt_before));
      if (cnt_before != 0) begin
        if (have_last) chk("t5_order", 64'(seen_pc), 64'(last_pc + 32'd4));
        last_pc   = seen_pc;
        have_last = 1'b1;
      end
    end

    // Reset in the middle of a request and of a drain; late responses ignored
    step(1, 0, 0, 0, 0, 0);
    chk("t6_arvalid", 64'(ifu_arvalid_o), 64'd0);
    chk("t6_araddr",  64'(ifu_araddr_o),  64'h3000_0000);
    chk("t6_count",   64'(count_o),       64'd0);
    step(0, 0, 0, 1, 32'h1111_2222, 0);
    chk("t6_late", 64'(count_o), 64'd0);
    step(0, 1, 32'h0000_1234, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("t6_drop_rst", 64'(ifu_araddr_o), 64'h3000_0000);
    step(0, 0, 0, 1, 32'h3333_4444, 0);
    chk("t6_late2", 64'(out_valid_o), 64'd0);

    // Address wrap at the top of the space
    step(0, 1, 32'hFFFF_FFFF, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, m_ph != 0, $urandom, 0);

    // Random traffic
    for (int i = 0; i < 600; i++)
      step(($urandom % 64) == 0, ($urandom % 12) == 0, $urandom,
           (m_ph != 0) && (($urandom % 3) == 0), $urandom, ($urandom % 2) == 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
